// File: rtl/lcd_bcd_display.sv
// HD44780-style LCD writer: runs the power-up init sequence, then redraws a row of
// BCD digits (optionally with leading-zero blanking) from a snapshot on each update request.
module lcd_bcd_display #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    update,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    E_out,
  output logic                    RW_out,
  output logic                    RS_out,
  output logic [7:0]              DB_out
);

  // state    | meaning
  // POWERUP  | 20-tick wait after reset before touching the LCD
  // INIT_WR  | init command writes (0x38, 0x0C, 0x01, 0x06), idx selects the command
  // CLR_WAIT | 2-tick settle after the clear-display command
  // IDLE     | ready, waiting for update or a pending request
  // ADDR_WR  | DDRAM address 0x80 write
  // DATA_WR  | one character per digit, idx counts down from the leftmost digit
  // DONE     | single-cycle frame-complete pulse
  typedef enum logic [2:0] {
    POWERUP, INIT_WR, CLR_WAIT, IDLE, ADDR_WR, DATA_WR, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [19:0]             div;
  logic                    tick;
  logic [1:0]              phase, phase_nxt;
  logic [3:0]              idx, idx_nxt;
  logic [4:0]              tcnt, tcnt_nxt;
  logic [4*NUM_DIGITS-1:0] snap, snap_nxt;
  logic                    pending, pending_nxt;
  logic                    launch, wr_state, wr_last;
  logic [NUM_DIGITS-1:0]   lz;
  logic [3:0]              cur;
  logic                    blank;
  logic [7:0]              char_code;

  assign tick = (div == 20'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      state   <= POWERUP;
      phase   <= '0;
      idx     <= '0;
      tcnt    <= '0;
      snap    <= '0;
      pending <= 1'b0;
    end else begin
      div     <= tick ? '0 : div + 20'd1;
      state   <= state_nxt;
      phase   <= phase_nxt;
      idx     <= idx_nxt;
      tcnt    <= tcnt_nxt;
      snap    <= snap_nxt;
      pending <= pending_nxt;
    end
  end

  assign wr_state = (state == INIT_WR) || (state == ADDR_WR) || (state == DATA_WR);
  assign wr_last  = wr_state && tick && (phase == 2'd2);

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    idx_nxt     = idx;
    tcnt_nxt    = tcnt;
    snap_nxt    = snap;
    pending_nxt = pending;
    launch      = 1'b0;
    if (update && state != IDLE) pending_nxt = 1'b1;
    if (wr_state && tick) phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
    case (state)
      POWERUP: if (tick) begin
        if (tcnt == 5'd19) begin
          state_nxt = INIT_WR;
          idx_nxt   = '0;
          phase_nxt = '0;
        end else begin
          tcnt_nxt = tcnt + 5'd1;
        end
      end
      INIT_WR: if (wr_last) begin
        if (idx == 4'd2) begin
          state_nxt = CLR_WAIT;
          tcnt_nxt  = '0;
          idx_nxt   = 4'd3;
        end else if (idx == 4'd3) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      CLR_WAIT: if (tick) begin
        if (tcnt == 5'd1) state_nxt = INIT_WR;
        else tcnt_nxt = tcnt + 5'd1;
      end
      IDLE: launch = update || pending;
      ADDR_WR: if (wr_last) begin
        state_nxt = DATA_WR;
        idx_nxt   = 4'(NUM_DIGITS - 1);
      end
      DATA_WR: if (wr_last) begin
        if (idx == 4'd0) state_nxt = DONE;
        else idx_nxt = idx - 4'd1;
      end
      DONE: begin
        // an update arriving in DONE chains straight into the next frame
        launch    = update || pending;
        state_nxt = IDLE;
      end
      default: state_nxt = POWERUP;
    endcase
    if (launch) begin
      state_nxt   = ADDR_WR;
      snap_nxt    = digits;
      pending_nxt = 1'b0;
      phase_nxt   = '0;
    end
  end

  always_comb begin
    logic above;
    above = 1'b1;
    lz    = '0;
    cur   = '0;
    blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above = above && (snap[4*i +: 4] == 4'd0);
      lz[i] = above;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 4'(i)) begin
        cur   = snap[4*i +: 4];
        blank = lz[i] && (i != 0);
      end
    end
    if (BLANK_LZ && blank) char_code = 8'h20;
    else if (cur <= 4'd9)  char_code = {4'h3, cur};
    else                   char_code = 8'h2D;
  end

  always_comb begin
    ready  = (state == IDLE) || (state == ADDR_WR) || (state == DATA_WR) || (state == DONE);
    busy   = (state != IDLE);
    done   = (state == DONE);
    RW_out = 1'b0;
    E_out  = wr_state && (phase == 2'd1);
    RS_out = 1'b0;
    DB_out = 8'h00;
    case (state)
      INIT_WR: case (idx[1:0])
        2'd0:    DB_out = 8'h38;
        2'd1:    DB_out = 8'h0C;
        2'd2:    DB_out = 8'h01;
        default: DB_out = 8'h06;
      endcase
      ADDR_WR: DB_out = 8'h80;
      DATA_WR: begin
        RS_out = 1'b1;
        DB_out = char_code;
      end
      default: DB_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_lcd_bcd_display.sv
// Directed bench for lcd_bcd_display: two instances (plain and leading-zero blanking)
// share all inputs; bytes are captured on each E_out rising edge.
module tb_lcd_bcd_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [15:0] digits = '0;

  logic ready_a, busy_a, done_a, e_a, rw_a, rs_a;
  logic [7:0] db_a;
  logic ready_b, busy_b, done_b, e_b, rw_b, rs_b;
  logic [7:0] db_b;

  lcd_bcd_display #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .reset(reset), .digits(digits), .update(update),
    .ready(ready_a), .busy(busy_a), .done(done_a), .E_out(e_a),
    .RW_out(rw_a), .RS_out(rs_a), .DB_out(db_a)
  );

  lcd_bcd_display #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .reset(reset), .digits(digits), .update(update),
    .ready(ready_b), .busy(busy_b), .done(done_b), .E_out(e_b),
    .RW_out(rw_b), .RS_out(rs_b), .DB_out(db_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_total = 0;
  int n_bad   = 0;

  logic [8:0] q_a[$];
  logic [7:0] q_b[$];
  int         wq[$];
  int         w = 0;
  logic       ea_prev = 1'b0;
  logic       eb_prev = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (e_a && !ea_prev) q_a.push_back({rs_a, db_a});
    if (e_b && !eb_prev) q_b.push_back(db_b);
    if (e_a) w++;
    else if (ea_prev) begin
      wq.push_back(w);
      w = 0;
    end
    ea_prev = e_a;
    eb_prev = e_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_done(input int s);
    return ((s / 4) + 1) * 4 + 56;
  endfunction

  task automatic clear_q();
    q_a.delete();
    q_b.delete();
    wq.delete();
  endtask

  task automatic pulse(output int s);
    update = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int d);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = done_a;
    end
    chk({tag, "_seen"}, 32'(hit), 32'd1);
    d = cyc;
  endtask

  task automatic do_init(input string tag);
    bit hit = 1'b0;
    logic [8:0] init_b [4] = '{9'h038, 9'h00C, 9'h001, 9'h006};
    clear_q();
    reset = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = ready_a;
    end
    chk({tag, "_ready"}, 32'(hit), 32'd1);
    chk({tag, "_cyc"}, 32'(cyc), 32'd136);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_nbytes"}, 32'(q_a.size()), 32'd4);
    chk({tag, "_nwidth"}, 32'(wq.size()), 32'd4);
    if (q_a.size() == 4 && wq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_cmd%0d", tag, i), 32'(q_a[i]), 32'(init_b[i]));
        chk($sformatf("%s_ewidth%0d", tag, i), 32'(wq[i]), 32'd4);
      end
  endtask

  task automatic frame(input string tag, input logic [15:0] d,
                       input logic [31:0] ea, input logic [31:0] eb);
    int s, dd;
    digits = d;
    clear_q();
    pulse(s);
    wait_done(tag, dd);
    chk({tag, "_lat"}, 32'(dd), 32'(exp_done(s)));
    chk({tag, "_na"}, 32'(q_a.size()), 32'd5);
    chk({tag, "_nb"}, 32'(q_b.size()), 32'd5);
    if (q_a.size() == 5 && q_b.size() == 5) begin
      chk({tag, "_addr"}, 32'(q_a[0]), 32'h080);
      for (int i = 1; i < 5; i++) begin
        chk($sformatf("%s_a%0d", tag, i), 32'(q_a[i]), 32'({1'b1, ea[8*(4-i) +: 8]}));
        chk($sformatf("%s_b%0d", tag, i), 32'(q_b[i]), 32'(eb[8*(4-i) +: 8]));
      end
    end
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done_a), 32'd0);
    chk({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_E"}, 32'(e_a), 32'd0);
    chk({tag, "_RW"}, 32'(rw_a), 32'd0);
    chk({tag, "_RS"}, 32'(rs_a), 32'd0);
    chk({tag, "_DB"}, 32'(db_a), 32'h00);
    chk({tag, "_ready"}, 32'(ready_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    int s, tmp, d1, d2, extra, nb;
    bit hit;
    logic [8:0] e;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    do_init("init");

    frame("f1290", 16'h1290, 32'h31323930, 32'h31323930);
    frame("f0070", 16'h0070, 32'h30303730, 32'h20203730);
    frame("f0000", 16'h0000, 32'h30303030, 32'h20202030);
    frame("fA005", 16'hA005, 32'h2D303035, 32'h2D303035);

    // three updates mid-frame merge into one more frame; digits change mid-frame
    digits = 16'h1111;
    clear_q();
    pulse(s);
    repeat (20) @(negedge clk);
    digits = 16'h2222;
    pulse(tmp);
    repeat (5) @(negedge clk);
    pulse(tmp);
    repeat (5) @(negedge clk);
    pulse(tmp);
    wait_done("merge1", d1);
    chk("merge1_lat", 32'(d1), 32'(exp_done(s)));
    @(negedge clk);
    chk("merge_start_busy", 32'(busy_a), 32'd1);
    chk("merge_start_done", 32'(done_a), 32'd0);
    wait_done("merge2", d2);
    chk("merge2_lat", 32'(d2), 32'(exp_done(d1 + 1)));
    @(negedge clk);
    chk("merge_idle", 32'(busy_a), 32'd0);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    chk("merge_extra", 32'(extra), 32'd0);
    chk("merge_nbytes", 32'(q_a.size()), 32'd10);
    if (q_a.size() == 10)
      for (int i = 0; i < 10; i++) begin
        e = (i % 5 == 0) ? 9'h080 : (i < 5 ? 9'h131 : 9'h132);
        chk($sformatf("merge_byte%0d", i), 32'(q_a[i]), 32'(e));
      end

    // update landing in the DONE cycle
    digits = 16'h3456;
    clear_q();
    pulse(s);
    wait_done("b2b1", d1);
    chk("b2b1_lat", 32'(d1), 32'(exp_done(s)));
    pulse(tmp);
    chk("b2b_start_busy", 32'(busy_a), 32'd1);
    chk("b2b_start_done", 32'(done_a), 32'd0);
    wait_done("b2b2", d2);
    chk("b2b2_lat", 32'(d2), 32'(exp_done(d1 + 1)));
    @(negedge clk);
    chk("b2b_idle", 32'(busy_a), 32'd0);
    chk("b2b_nbytes", 32'(q_a.size()), 32'd10);
    if (q_a.size() == 10)
      for (int i = 0; i < 10; i++) begin
        e = (i % 5 == 0) ? 9'h080 : {5'b1_0011, 4'(2 + (i % 5))};
        chk($sformatf("b2b_byte%0d", i), 32'(q_a[i]), 32'(e));
      end

    // reset during the third data byte, with a request pending
    digits = 16'h1290;
    clear_q();
    pulse(s);
    repeat (3) @(negedge clk);
    pulse(tmp);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (q_a.size() == 4);
    end
    chk("midrst_reach", 32'(hit), 32'd1);
    chk("midrst_strobe", 32'(e_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    do_init("reinit");
    nb = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy_a) nb++;
    end
    chk("reinit_no_pending", 32'(nb), 32'd0);
    chk("reinit_nbytes", 32'(q_a.size()), 32'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
